// File: rtl/spi_read_arbiter.sv
// spi_read_arbiter
//   Shares one SPI read engine among NREQ requesters using round-robin
//   arbitration. Only one transaction runs at a time. After each
//   transaction the arbiter holds an idle gap so that nCS stays high long
//   enough. A watchdog aborts a transaction if the engine never reports done.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   req         level request per requester, held until its ack
//   ack         one-hot, one-cycle completion pulse; rdata/err valid with it
//   rdata       result of the last transaction, held until the next completion
//   err         1 = the last completion was a timeout; held like rdata
//   eng_start   one-cycle start pulse to the SPI engine
//   eng_done    one-cycle done pulse from the SPI engine
//   eng_data    engine result, valid when eng_done=1
//   busy        high from START through the end of GAP
//   cur_grant   one-hot owner of the current transaction, 0 when idle
//   timeout_cnt saturating count of timeouts
module spi_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 13,
  parameter int TIMEOUT = 2048,
  parameter int GAP_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            eng_start,
  input  logic            eng_done,
  input  logic [DW-1:0]   eng_data,
  output logic            busy,
  output logic [NREQ-1:0] cur_grant,
  output logic [7:0]      timeout_cnt
);

  localparam int PW       = $clog2(NREQ);
  localparam int TW       = $clog2(TIMEOUT);
  localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DELIVER,
    S_GAP
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   grant_idx_reg;
  logic [TW-1:0]   timer_reg;
  logic [GW-1:0]   gap_reg;
  logic [NREQ-1:0] ack_reg;
  logic [DW-1:0]   rdata_reg;
  logic            err_reg;
  logic            eng_start_reg;
  logic            busy_reg;
  logic [NREQ-1:0] cur_grant_reg;
  logic [7:0]      timeout_cnt_reg;

  // Request vector rotated so that bit 0 is the requester the pointer
  // currently favours; the lowest set bit of rot_req is then the winner.
  logic [NREQ-1:0] rot_req;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot_req[gi] = req[PW'((int'(ptr_reg) + gi) % NREQ)];
    end
  endgenerate

  // Scan from the top down so the lowest rotated position overwrites last.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_idx = PW'((int'(ptr_reg) + i) % NREQ);
      end
    end
  end

  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      grant_idx_reg   <= '0;
      timer_reg       <= '0;
      gap_reg         <= '0;
      ack_reg         <= '0;
      rdata_reg       <= '0;
      err_reg         <= 1'b0;
      eng_start_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      cur_grant_reg   <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      // Pulse outputs default low; they are raised only on the entry edge.
      ack_reg       <= '0;
      eng_start_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            cur_grant_reg <= win_oh;
            grant_idx_reg <= win_idx;
            eng_start_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= S_START;
          end
        end

        S_START: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          timer_reg <= timer_reg + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (eng_done) begin
            rdata_reg <= eng_data;
            err_reg   <= 1'b0;
            ack_reg   <= cur_grant_reg;
            state_reg <= S_DELIVER;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
            ack_reg   <= cur_grant_reg;
            if (timeout_cnt_reg != 8'hFF) begin
              timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
            state_reg <= S_DELIVER;
          end
        end

        S_DELIVER: begin
          ptr_reg <= PW'((int'(grant_idx_reg) + 1) % NREQ);
          gap_reg <= '0;
          if (GAP_CYC == 0) begin
            busy_reg      <= 1'b0;
            cur_grant_reg <= '0;
            state_reg     <= S_IDLE;
          end else begin
            state_reg <= S_GAP;
          end
        end

        S_GAP: begin
          gap_reg <= gap_reg + 1'b1;
          if (gap_reg == GW'(GAP_LAST)) begin
            busy_reg      <= 1'b0;
            cur_grant_reg <= '0;
            state_reg     <= S_IDLE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_reg;
  assign rdata       = rdata_reg;
  assign err         = err_reg;
  assign eng_start   = eng_start_reg;
  assign busy        = busy_reg;
  assign cur_grant   = cur_grant_reg;
  assign timeout_cnt = timeout_cnt_reg;

endmodule
